// File: rtl/sysid_check_pkg.sv
// -----------------------------------------------------------------------------
// sysid_check_pkg
// Shared types and helpers for the boot-time system-ID check sequencer.
//   state_e  : sequencer state encoding (3-bit)
//   ADDR_ID  : slave word holding the system ID
//   ADDR_TS  : slave word holding the build timestamp
//   clog2()  : bit width needed to hold the values 0..value-1
// -----------------------------------------------------------------------------
package sysid_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_RD_TS   = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Called with (limit + 1) so the result can represent 0..limit.
    // Never returns less than 1 so a limit of 0 still yields a legal vector.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/sysid_check_ctrl_if.sv
// -----------------------------------------------------------------------------
// sysid_check_ctrl_if
// Avalon-MM read-only link between the check sequencer and the system-ID slave.
//   avm_address     : word select (0 = ID, 1 = timestamp), master -> slave
//   avm_read        : read strobe, master -> slave
//   avm_waitrequest : slave stall, slave -> master
//   avm_readdata    : 32-bit read data, slave -> master
// -----------------------------------------------------------------------------
interface sysid_check_ctrl_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/sysid_check_timeout.sv
// -----------------------------------------------------------------------------
// sysid_check_timeout
// Stall counter for one read attempt. Counts cycles while enable is high,
// saturates at LIMIT and flags terminal once LIMIT stalled cycles have been
// seen, so the next stalled cycle is the one that exceeds the allowance.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : return the count to zero (takes priority over enable)
//   enable         : count this cycle
//   terminal       : count has reached LIMIT
// -----------------------------------------------------------------------------
module sysid_check_timeout
    import sysid_check_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int               CNT_W   = clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] ONE_V   = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign terminal = (count_q == LIMIT_V);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !terminal) begin
            count_d = count_q + ONE_V;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// sysid_check_ctrl
// Boot-time sequencer: reads system-ID word 0 and timestamp word 1 over
// Avalon-MM, compares them with generation-time constants and reports the
// result. Every output is a flop.
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : one-cycle request to run a check (ignored while busy)
//   avm            : Avalon-MM master port (address, read, waitrequest, readdata)
//   busy           : sequence in progress
//   done           : sequence finished, held until the next accepted start
//   id_ok, ts_ok   : comparison results, valid while done
//   timeout_err    : sequence aborted after exhausting read retries
//   id_value       : last captured word 0
//   ts_value       : last captured word 1
// -----------------------------------------------------------------------------
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1486089823,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    sysid_check_ctrl_if.master avm,
    output logic               busy,
    output logic               done,
    output logic               id_ok,
    output logic               ts_ok,
    output logic               timeout_err,
    output logic [31:0]        id_value,
    output logic [31:0]        ts_value
);

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic [3:0]  retry_q, retry_d;
    logic        autostart_q, autostart_d;
    logic        read_q, read_d;
    logic        address_q, address_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_err_q, timeout_err_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic        in_read;
    logic        launch;
    logic [3:0]  retry_inc;
    logic        tmo_clear;
    logic        tmo_enable;
    logic        tmo_terminal;

    assign in_read   = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
    assign retry_inc = retry_q + 4'd1;

    // Autostart only applies from IDLE; from DONE only an explicit start counts.
    assign launch = ((state_q == ST_IDLE) && (start || autostart_q)) ||
                    ((state_q == ST_DONE) && start);

    // Any state change (including BACKOFF back into a read) restarts the
    // stall count, so each read attempt gets the full allowance.
    assign tmo_clear  = (state_d != state_q);
    assign tmo_enable = in_read && avm.avm_waitrequest;

    sysid_check_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (tmo_clear),
        .enable   (tmo_enable),
        .terminal (tmo_terminal)
    );

    // Next-state and next-output logic. Outputs are derived from the next
    // state so that they are registered alongside it.
    always_comb begin
        state_d       = state_q;
        retry_d       = retry_q;
        autostart_d   = autostart_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d       = ST_RD_ID;
                    autostart_d   = 1'b0;
                    retry_d       = 4'd0;
                    id_ok_d       = 1'b0;
                    ts_ok_d       = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                if (!avm.avm_waitrequest) begin
                    if (state_q == ST_RD_ID) begin
                        id_value_d = avm.avm_readdata;
                        state_d    = ST_RD_TS;
                    end else begin
                        ts_value_d = avm.avm_readdata;
                        state_d    = ST_COMPARE;
                    end
                end else if (tmo_terminal) begin
                    // Retries are counted across both reads of one sequence.
                    retry_d = retry_inc;
                    if (retry_inc < RETRY_LIMIT) begin
                        state_d = ST_BACKOFF;
                    end else begin
                        state_d       = ST_DONE;
                        timeout_err_d = 1'b1;
                        id_ok_d       = 1'b0;
                        ts_ok_d       = 1'b0;
                    end
                end
            end
            ST_BACKOFF: begin
                // The address flop still holds the word that stalled.
                state_d = (address_q == ADDR_TS) ? ST_RD_TS : ST_RD_ID;
            end
            ST_COMPARE: begin
                id_ok_d = (id_value_q == EXPECTED_ID);
                ts_ok_d = (ts_value_q == EXPECTED_TS);
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        read_d    = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
        busy_d    = read_d || (state_d == ST_BACKOFF) || (state_d == ST_COMPARE);
        done_d    = (state_d == ST_DONE);
        address_d = address_q;
        if (state_d == ST_RD_ID) begin
            address_d = ADDR_ID;
        end else if (state_d == ST_RD_TS) begin
            address_d = ADDR_TS;
        end
    end

    // State and output registers; reset re-arms the autostart flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            retry_q       <= 4'd0;
            autostart_q   <= AUTO_START;
            read_q        <= 1'b0;
            address_q     <= ADDR_ID;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            id_value_q    <= 32'd0;
            ts_value_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            retry_q       <= retry_d;
            autostart_q   <= autostart_d;
            read_q        <= read_d;
            address_q     <= address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_err_q <= timeout_err_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

    assign avm.avm_read    = read_q;
    assign avm.avm_address = address_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign timeout_err     = timeout_err_q;
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_ctrl
// Self-checking bench for sysid_check_ctrl. dut_a uses the default parameters
// (autostart, 255-cycle stall allowance, 3 attempts); dut_b uses a 4-cycle
// allowance, 2 attempts and no autostart so that retry exhaustion is short.
// Each slave model returns a fixed word per address and stalls a programmed
// number of cycles per word.
// -----------------------------------------------------------------------------
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_TS = 32'd1486089823;

    typedef struct {
        logic [31:0] id_word;
        logic [31:0] ts_word;
        int          stall_id;
        int          stall_ts;
        int          exp_done_cycle;
        logic        exp_id_ok;
        logic        exp_ts_ok;
        logic        exp_terr;
        int          exp_addr0;
        int          exp_addr1;
        int          exp_noread;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic        start_a;
    logic        start_b;
    logic        wait_a;
    logic        wait_b;
    logic [31:0] slave_a_id, slave_a_ts;
    logic [31:0] slave_b_id, slave_b_ts;
    int          stall_a_id, stall_a_ts;
    int          stall_b_id, stall_b_ts;

    logic        busy_a, done_a, id_ok_a, ts_ok_a, terr_a;
    logic [31:0] id_value_a, ts_value_a;
    logic        busy_b, done_b, id_ok_b, ts_ok_b, terr_b;
    logic [31:0] id_value_b, ts_value_b;

    int vectors;
    int miscompares;

    vec_t vec_table[8];

    sysid_check_ctrl_if bus_a ();
    sysid_check_ctrl_if bus_b ();

    assign bus_a.avm_waitrequest = wait_a;
    assign bus_a.avm_readdata    = bus_a.avm_address ? slave_a_ts : slave_a_id;
    assign bus_b.avm_waitrequest = wait_b;
    assign bus_b.avm_readdata    = bus_b.avm_address ? slave_b_ts : slave_b_id;

    sysid_check_ctrl dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start_a),
        .avm         (bus_a),
        .busy        (busy_a),
        .done        (done_a),
        .id_ok       (id_ok_a),
        .ts_ok       (ts_ok_a),
        .timeout_err (terr_a),
        .id_value    (id_value_a),
        .ts_value    (ts_value_a)
    );

    sysid_check_ctrl #(
        .TIMEOUT_CYCLES (4),
        .MAX_RETRIES    (2),
        .AUTO_START     (1'b0)
    ) dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start_b),
        .avm         (bus_b),
        .busy        (busy_b),
        .done        (done_b),
        .id_ok       (id_ok_b),
        .ts_ok       (ts_ok_b),
        .timeout_err (terr_b),
        .id_value    (id_value_b),
        .ts_value    (ts_value_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Slave stall model: decides waitrequest for the cycle now in progress.
    task automatic driveSlave();
        wait_a = 1'b0;
        if (bus_a.avm_read) begin
            if (!bus_a.avm_address && stall_a_id > 0) begin
                wait_a = 1'b1;
                stall_a_id--;
            end else if (bus_a.avm_address && stall_a_ts > 0) begin
                wait_a = 1'b1;
                stall_a_ts--;
            end
        end
        wait_b = 1'b0;
        if (bus_b.avm_read) begin
            if (!bus_b.avm_address && stall_b_id > 0) begin
                wait_b = 1'b1;
                stall_b_id--;
            end else if (bus_b.avm_address && stall_b_ts > 0) begin
                wait_b = 1'b1;
                stall_b_ts--;
            end
        end
    endtask

    task automatic nextCycle();
        @(negedge clock);
        driveSlave();
    endtask

    // Pulse start for one cycle; returns at the negedge of cycle 1.
    task automatic pulseStart(input bit sel_b);
        if (sel_b) start_b = 1'b1;
        else       start_a = 1'b1;
        nextCycle();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Index (from the current cycle = 1) of the first cycle with done high.
    task automatic waitDone(input bit sel_b, input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            if (sel_b ? done_b : done_a) begin
                k = i;
                return;
            end
            nextCycle();
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_read"},     32'(bus_a.avm_read),    32'd0);
        checkOutput({tag, "_address"},  32'(bus_a.avm_address), 32'd0);
        checkOutput({tag, "_busy"},     32'(busy_a),            32'd0);
        checkOutput({tag, "_done"},     32'(done_a),            32'd0);
        checkOutput({tag, "_id_ok"},    32'(id_ok_a),           32'd0);
        checkOutput({tag, "_ts_ok"},    32'(ts_ok_a),           32'd0);
        checkOutput({tag, "_terr"},     32'(terr_a),            32'd0);
        checkOutput({tag, "_id_value"}, id_value_a,             32'd0);
        checkOutput({tag, "_ts_value"}, ts_value_a,             32'd0);
    endtask

    // Runs one full sequence on dut_a from DONE and gathers bus statistics.
    task automatic applyStimulus(input vec_t v, output int done_k, output int a0,
                                 output int a1, output int nr);
        slave_a_id = v.id_word;
        slave_a_ts = v.ts_word;
        stall_a_id = v.stall_id;
        stall_a_ts = v.stall_ts;
        a0 = 0;
        a1 = 0;
        nr = 0;
        done_k = -1;
        pulseStart(1'b0);
        for (int k = 1; k <= 400; k++) begin
            if (bus_a.avm_read && !bus_a.avm_address) a0++;
            if (bus_a.avm_read && bus_a.avm_address)  a1++;
            if (busy_a && !bus_a.avm_read)            nr++;
            if (done_a) begin
                done_k = k;
                break;
            end
            nextCycle();
        end
    endtask

    initial begin
        int          done_k, a0, a1, nr, k;
        logic [15:0] seq_obs;
        logic [11:0] rd_pat, dn_pat;

        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        start_a     = 1'b0;
        start_b     = 1'b0;
        wait_a      = 1'b0;
        wait_b      = 1'b0;
        slave_a_id  = 32'd0;
        slave_a_ts  = EXP_TS;
        slave_b_id  = 32'd0;
        slave_b_ts  = EXP_TS;
        stall_a_id  = 0;
        stall_a_ts  = 0;
        stall_b_id  = 0;
        stall_b_ts  = 0;

        //                 id_word        ts_word   sid  sts  done id ts te a0   a1   nr
        vec_table[0] = '{32'd0,         EXP_TS,     0,   0,   4, 1, 1, 0,   1,   1, 1};
        vec_table[1] = '{32'd0,         32'd1,      0,   0,   4, 1, 0, 0,   1,   1, 1};
        vec_table[2] = '{32'd0,         EXP_TS,     3,   0,   7, 1, 1, 0,   4,   1, 1};
        vec_table[3] = '{32'hDEADBEEF,  EXP_TS,     0,   2,   6, 0, 1, 0,   1,   3, 1};
        vec_table[4] = '{32'd1,         32'd0,      2,   1,   7, 0, 0, 0,   3,   2, 1};
        vec_table[5] = '{32'd0,         EXP_TS,   255,   0, 259, 1, 1, 0, 256,   1, 1};
        vec_table[6] = '{32'd0,         EXP_TS,   256,   0, 261, 1, 1, 0, 257,   1, 2};
        vec_table[7] = '{32'd0,         EXP_TS,     0, 256, 261, 1, 1, 0,   1, 257, 2};

        repeat (2) @(negedge clock);
        checkResetState("por");
        checkOutput("por_busy_b", 32'(busy_b), 32'd0);

        // Autostart after release: {read, address, busy, done} per cycle 1..4.
        reset_n = 1'b1;
        seq_obs = '0;
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            seq_obs = {seq_obs[11:0], bus_a.avm_read, bus_a.avm_address, busy_a, done_a};
        end
        checkOutput("auto_seq", 32'(seq_obs), 32'h0000_AE65);
        checkOutput("auto_id_ok", 32'(id_ok_a), 32'd1);
        checkOutput("auto_ts_ok", 32'(ts_ok_a), 32'd1);
        checkOutput("auto_terr",  32'(terr_a),  32'd0);
        checkOutput("auto_off_b", 32'(busy_b),  32'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vec_table[i], done_k, a0, a1, nr);
            checkOutput($sformatf("v%0d_done_cycle", i), 32'(done_k), 32'(vec_table[i].exp_done_cycle));
            checkOutput($sformatf("v%0d_id_ok", i), 32'(id_ok_a), 32'(vec_table[i].exp_id_ok));
            checkOutput($sformatf("v%0d_ts_ok", i), 32'(ts_ok_a), 32'(vec_table[i].exp_ts_ok));
            checkOutput($sformatf("v%0d_terr", i), 32'(terr_a), 32'(vec_table[i].exp_terr));
            checkOutput($sformatf("v%0d_id_value", i), id_value_a, vec_table[i].id_word);
            checkOutput($sformatf("v%0d_ts_value", i), ts_value_a, vec_table[i].ts_word);
            checkOutput($sformatf("v%0d_addr0_cycles", i), 32'(a0), 32'(vec_table[i].exp_addr0));
            checkOutput($sformatf("v%0d_addr1_cycles", i), 32'(a1), 32'(vec_table[i].exp_addr1));
            checkOutput($sformatf("v%0d_busy_noread", i), 32'(nr), 32'(vec_table[i].exp_noread));
        end

        // Start during a stalled RD_TS and during its capture cycle is ignored.
        slave_a_id = 32'd0;
        slave_a_ts = EXP_TS;
        stall_a_ts = 2;
        pulseStart(1'b0);
        nextCycle();
        nextCycle();
        start_a = 1'b1;
        nextCycle();
        nextCycle();
        start_a = 1'b0;
        waitDone(1'b0, 20, k);
        checkOutput("busy_start_done_cycle", 32'(k), 32'd2);
        nextCycle();
        checkOutput("busy_start_no_queue_done", 32'(done_a), 32'd1);
        checkOutput("busy_start_no_queue_busy", 32'(busy_a), 32'd0);
        pulseStart(1'b0);
        checkOutput("restart_done_clr", 32'(done_a), 32'd0);
        checkOutput("restart_busy",     32'(busy_a), 32'd1);
        checkOutput("restart_id_ok_clr", 32'(id_ok_a), 32'd0);
        checkOutput("restart_ts_ok_clr", 32'(ts_ok_a), 32'd0);
        checkOutput("restart_read_addr", 32'({bus_a.avm_read, bus_a.avm_address}), 32'd2);
        waitDone(1'b0, 20, k);
        checkOutput("restart_done_cycle", 32'(k), 32'd4);

        // dut_b: waitrequest stuck high on word 0, two attempts then abort.
        stall_b_id = 1000;
        stall_b_ts = 0;
        pulseStart(1'b1);
        rd_pat = '0;
        dn_pat = '0;
        for (int c = 1; c <= 12; c++) begin
            rd_pat[c-1] = bus_b.avm_read;
            dn_pat[c-1] = done_b;
            if (c < 12) nextCycle();
        end
        checkOutput("stuck_read_pattern", 32'(rd_pat), 32'h0000_07DF);
        checkOutput("stuck_done_pattern", 32'(dn_pat), 32'h0000_0800);
        checkOutput("stuck_terr",  32'(terr_b),  32'd1);
        checkOutput("stuck_id_ok", 32'(id_ok_b), 32'd0);
        checkOutput("stuck_ts_ok", 32'(ts_ok_b), 32'd0);
        checkOutput("stuck_addr",  32'(bus_b.avm_address), 32'd0);

        stall_b_id = 0;
        pulseStart(1'b1);
        checkOutput("b_restart_terr_clr", 32'(terr_b), 32'd0);
        waitDone(1'b1, 20, k);
        checkOutput("b_restart_done_cycle", 32'(k), 32'd4);
        checkOutput("b_restart_id_ok", 32'(id_ok_b), 32'd1);
        checkOutput("b_restart_ts_ok", 32'(ts_ok_b), 32'd1);

        // dut_b: one timeout on each word exhausts the shared retry budget.
        slave_b_id = 32'h1234_5678;
        stall_b_id = 5;
        stall_b_ts = 5;
        pulseStart(1'b1);
        waitDone(1'b1, 40, k);
        checkOutput("shared_retry_done_cycle", 32'(k), 32'd13);
        checkOutput("shared_retry_terr", 32'(terr_b), 32'd1);
        checkOutput("shared_retry_id_value", id_value_b, 32'h1234_5678);
        checkOutput("shared_retry_ts_hold", ts_value_b, EXP_TS);
        checkOutput("shared_retry_id_ok", 32'(id_ok_b), 32'd0);

        // Reset during a stalled RD_TS, then autostart reruns the check.
        slave_a_id = 32'h0000_00A5;
        slave_a_ts = 32'd1;
        stall_a_ts = 1000;
        pulseStart(1'b0);
        nextCycle();
        nextCycle();
        checkOutput("pre_reset_read_addr", 32'({bus_a.avm_read, bus_a.avm_address}), 32'd3);
        #2 reset_n = 1'b0;
        #1 checkResetState("midreset");
        stall_a_ts = 0;
        slave_a_id = 32'd0;
        slave_a_ts = EXP_TS;
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        waitDone(1'b0, 20, k);
        checkOutput("rerun_done_cycle", 32'(k), 32'd4);
        checkOutput("rerun_id_ok", 32'(id_ok_a), 32'd1);
        checkOutput("rerun_ts_ok", 32'(ts_ok_a), 32'd1);
        checkOutput("rerun_b_idle", 32'({busy_b, done_b}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
